// File: rtl/boot_loader_pkg.sv
// Shared definitions for the program-load stage: state encodings, default frame marker and
// the COUNT-field range check.
package boot_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StCount = 3'd1;
  localparam state_t StData  = 3'd2;
  localparam state_t StWrite = 3'd3;
  localparam state_t StCsum  = 3'd4;
  localparam state_t StDone  = 3'd5;
  localparam state_t StErr   = 3'd6;

  localparam logic [7:0] SyncDefault = 8'hA5;

  // A frame must carry at least one word and must fit above the base address.
  function automatic logic count_ok(input logic [7:0] n, input int unsigned max_words);
    return (n != 8'd0) && (32'(n) <= max_words);
  endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream handshake and memory-port signals between the loader and its neighbours.
interface boot_loader_if #(
  parameter int unsigned ADDR_W = 7
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              LD_CS;
  logic              LD_WE;
  logic [ADDR_W-1:0] LD_ADDR;
  logic [31:0]       LD_DATA;
  logic              BUS_OWN;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, LD_CS, LD_WE, LD_ADDR, LD_DATA, BUS_OWN
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, LD_CS, LD_WE, LD_ADDR, LD_DATA, BUS_OWN
  );
endinterface

// File: rtl/boot_loader_word_pack.sv
// Big-endian byte-to-word shifter with a byte counter and running XOR checksum.
module boot_loader_word_pack (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        load_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic [7:0]  csum_o,
  output logic        last_o
);

  logic [31:0] word_q, word_d;
  logic [7:0]  csum_q, csum_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    csum_d = csum_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      word_d = '0;
      csum_d = '0;
      cnt_d  = '0;
    end else if (load_i) begin
      word_d = {word_q[23:0], byte_i};
      csum_d = csum_q ^ byte_i;
      cnt_d  = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
      csum_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      csum_q <= csum_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o = word_q;
  assign csum_o = csum_q;
  // High while the byte about to be loaded completes a word.
  assign last_o = (cnt_q == 2'd3);

endmodule

// File: rtl/boot_loader.sv
// Framed byte-stream program loader: writes words into memory and releases the CPU from reset
// once the frame checksum matches.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = 7,
  parameter logic [7:0]  SYNC_BYTE   = SyncDefault,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic          CLK,
  input  logic          RST,
  boot_loader_if.master bus,
  output logic          CPU_RST,
  output logic          done,
  output logic          err
);

  localparam int unsigned MaxWords = (1 << ADDR_W) - BASE_ADDR;
  localparam int unsigned TmoW     = $clog2(TIMEOUT_CYC + 1);

  state_t          state_q, state_d;
  logic [7:0]      idx_q, idx_d;
  logic [7:0]      n_q, n_d;
  logic [TmoW-1:0] tmo_q, tmo_d;

  logic        xfer;
  logic        pk_clr, pk_load, pk_last;
  logic [31:0] pk_word;
  logic [7:0]  pk_csum;

  assign xfer = bus.rx_valid & bus.rx_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    tmo_d   = '0;
    pk_clr  = 1'b0;
    pk_load = 1'b0;
    case (state_q)
      StIdle, StErr: begin
        if (xfer && bus.rx_data == SYNC_BYTE) begin
          state_d = StCount;
          idx_d   = '0;
          pk_clr  = 1'b1;
        end
      end
      StCount: begin
        if (xfer) begin
          if (count_ok(bus.rx_data, MaxWords)) begin
            n_d     = bus.rx_data;
            state_d = StData;
          end else begin
            state_d = StErr;
          end
        end
      end
      StData: begin
        if (xfer) begin
          pk_load = 1'b1;
          if (pk_last) state_d = StWrite;
        end
      end
      StWrite: begin
        idx_d   = idx_q + 8'd1;
        state_d = (idx_q + 8'd1 == n_q) ? StCsum : StData;
      end
      StCsum: begin
        if (xfer) state_d = (bus.rx_data == pk_csum) ? StDone : StErr;
      end
      StDone: ;
      default: state_d = StIdle;
    endcase

    // Idle time only counts while a frame is in progress and waiting on the stream.
    if ((state_q == StCount || state_q == StData || state_q == StCsum) && !xfer) begin
      if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) state_d = StErr;
      else tmo_d = tmo_q + TmoW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      idx_q   <= '0;
      n_q     <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      tmo_q   <= tmo_d;
    end
  end

  boot_loader_word_pack u_word_pack (
    .clk_i  (CLK),
    .rst_ni (RST),
    .clr_i  (pk_clr),
    .load_i (pk_load),
    .byte_i (bus.rx_data),
    .word_o (pk_word),
    .csum_o (pk_csum),
    .last_o (pk_last)
  );

  assign bus.rx_ready = (state_q != StWrite);
  assign bus.LD_CS    = (state_q == StWrite);
  assign bus.LD_WE    = (state_q == StWrite);
  assign bus.LD_ADDR  = ADDR_W'(BASE_ADDR + 32'(idx_q));
  assign bus.LD_DATA  = pk_word;
  assign bus.BUS_OWN  = (state_q != StDone);
  assign CPU_RST      = (state_q != StDone);
  assign done         = (state_q == StDone);
  assign err          = (state_q == StErr);

endmodule
